fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage for the single-cycle MIPS core; sits directly upstream of the main decoder.
//  Owns the PC register, fetches from instruction memory over a req/ready handshake, and holds the
//  instruction stable for decode (opcode=inst[31:26], func=inst[5:0]).
//  Consumes the decoder's pc_src/jctrl/jrctrl/jalctrl to select the next PC. Supplies pc_plus4 as the
//  jal link value.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  TIMEOUT    16             max cycles waiting for imem_ready before fetch_err (>=1)
// PORTS
//  clk         in   1   single clock, all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  imem_req    out  1   fetch request to instruction memory
//  imem_addr   out  32  fetch address (= pc); bits[1:0] always 0
//  imem_ready  in   1   memory accepts request; imem_rdata valid in the same cycle
//  imem_rdata  in   32  instruction word
//  inst        out  32  held instruction for decode
//  inst_valid  out  1   inst/pc/pc_plus4 valid for decode
//  commit      in   1   core has executed inst this cycle; advance PC
//  pc_src      in   1   branch taken (branch & zero) from decoder
//  jctrl       in   1   j/jal from decoder
//  jrctrl      in   1   jr from decoder
//  jalctrl     in   1   jal from decoder (informational; target same as j)
//  jr_target   in   32  register-file rs value for jr
//  pc          out  32  address of inst
//  pc_plus4    out  32  pc + 4 (jal link value)
//  fetch_err   out  1   sticky: imem did not respond within TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, state=REQ, inst=0, inst_valid=0, fetch_err=0,
//    wait counter=0. Any outstanding fetch is abandoned; imem_ready in that cycle is ignored.
//  FSM states: REQ, HOLD, ERR.
//   REQ: imem_req=1, imem_addr=pc held stable. On imem_ready=1: inst<=imem_rdata, inst_valid<=1,
//     cnt<=0, ->HOLD. Otherwise cnt++; when cnt reaches TIMEOUT-1 without ready: fetch_err<=1, ->ERR.
//   HOLD: imem_req=0, inst_valid=1. If commit=0, stay. If commit=1: pc<=next_pc, inst_valid<=0, ->REQ.
//   ERR: imem_req=0, inst_valid=0. Leaves only via rst. fetch_err stays 1 until reset.
//  Latency: with zero-wait memory, inst_valid rises 1 cycle after entering REQ. Each instruction
//    takes min 2 cycles (REQ, HOLD+commit).
//  commit is ignored outside HOLD. Decoder inputs and jr_target are sampled only when commit=1 in HOLD.
//  next_pc priority (highest first):
//   jrctrl  : {jr_target[31:2],2'b00}  (misaligned low bits silently cleared)
//   jctrl   : {pc_plus4[31:28], inst[25:0], 2'b00}
//   pc_src  : pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}
//   else    : pc_plus4
//  Arithmetic is 32-bit modulo: pc 32'hFFFF_FFFC + 4 wraps to 0, and branch targets wrap likewise.
//  pc_plus4 = pc + 4, combinational from the pc register.
//  Simultaneous rst and imem_ready or commit: rst wins.
// TESTING
//  1. rst then zero-wait imem (ready=1): cycle after reset imem_req=1, imem_addr=0.
//     inst_valid=1, inst=rdata next cycle. commit -> imem_addr=4.
//  2. beq at pc=0x10, inst[15:0]=16'hFFFE, pc_src=1, commit -> next imem_addr=0x0C.
//     Same with pc_src=0 -> 0x14.
//  3. j at pc=0x4000_0000, inst[25:0]=26'h000_0010, jctrl=1 (also jalctrl=1) -> imem_addr=0x4000_0040.
//     pc_plus4=0x4000_0004 during HOLD.
//  4. jrctrl=1 with jctrl=1 and pc_src=1, jr_target=0x0000_0123 -> imem_addr=0x0000_0120 (jr priority, bits cleared).
//  5. imem_ready low 3 cycles then high (TIMEOUT=16): imem_addr stable 4 cycles, inst_valid only after
//     ready, fetch_err=0. Ready never high: fetch_err=1 after 16 REQ cycles, stays 1 until rst.
//  6. rst asserted in REQ with imem_ready=1 same cycle -> inst_valid=0, pc=RESET_PC.
//     commit held high in REQ -> no PC change. pc=0xFFFF_FFFC sequential commit -> imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage for the single-cycle MIPS core. Owns the PC,
//   fetches one instruction at a time from instruction memory over a
//   req/ready handshake, and holds it stable for the decoder until the core
//   commits it. The decoder's control outputs then select the next PC.
//
// Parameters
//   RESET_PC  PC loaded on reset (low two bits are forced to zero)
//   TIMEOUT   max REQ cycles without imem_ready before fetch_err (>=1)
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   imem_req/addr       fetch request and word address (= pc)
//   imem_ready/rdata    memory accept, instruction word valid same cycle
//   inst, inst_valid    held instruction for decode
//   commit              core executed inst; advance the PC
//   pc_src/jctrl/jrctrl/jalctrl, jr_target   next-PC selection from decode
//   pc, pc_plus4        address of inst and its jal link value
//   fetch_err           sticky memory timeout flag, cleared only by reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        commit,
  input  logic        pc_src,
  input  logic        jctrl,
  input  logic        jrctrl,
  input  logic        jalctrl,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   inst_reg;
  logic [CW-1:0] cnt_reg;
  logic          fetch_err_reg;
  logic          timeout_hit;
  logic [31:0]   seq_pc, branch_off;

  // jalctrl shares the j target; only the decoder/regfile care about it.
  // jr_target low bits are discarded when forming the aligned target.
  logic unused_inputs;
  assign unused_inputs = ^{jalctrl, jr_target[1:0]};

  assign timeout_hit = (cnt_reg == CNT_LAST);

  // Next-PC selection: jr > j/jal > taken branch > sequential.
  assign seq_pc     = pc_reg + 32'd4;
  assign branch_off = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};

  always_comb begin
    pc_next = seq_pc;
    if (jrctrl)
      pc_next = {jr_target[31:2], 2'b00};
    else if (jctrl)
      pc_next = {seq_pc[31:28], inst_reg[25:0], 2'b00};
    else if (pc_src)
      pc_next = seq_pc + branch_off;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= ST_REQ;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_REQ: begin
        if (imem_ready)
          state_next = ST_HOLD;
        else if (timeout_hit)
          state_next = ST_ERR;
      end
      ST_HOLD: begin
        if (commit)
          state_next = ST_REQ;
      end
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_REQ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state_reg)
      ST_REQ:  imem_req   = 1'b1;
      ST_HOLD: inst_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: PC, held instruction, wait counter, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= RESET_PC_ALIGNED;
      inst_reg      <= 32'd0;
      cnt_reg       <= '0;
      fetch_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (imem_ready) begin
            inst_reg <= imem_rdata;
            cnt_reg  <= '0;
          end else if (timeout_hit) begin
            fetch_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          if (commit)
            pc_reg <= pc_next;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign pc_plus4  = seq_pc;
  assign inst      = inst_reg;
  assign fetch_err = fetch_err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        commit = 1'b0;
  logic        pc_src = 1'b0;
  logic        jctrl = 1'b0;
  logic        jrctrl = 1'b0;
  logic        jalctrl = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .commit(commit), .pc_src(pc_src), .jctrl(jctrl), .jrctrl(jrctrl),
    .jalctrl(jalctrl), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC, written straight from the MIPS rules.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc,
                                              input logic [31:0] word,
                                              input logic br, input logic j,
                                              input logic jr,
                                              input logic [31:0] tgt);
    logic [31:0] link;
    int          off;
    link = cur_pc + 32'd4;
    if (jr) return tgt & 32'hFFFF_FFFC;
    if (j)  return (link & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    if (br) begin
      off = int'($signed(word[15:0])) * 4;
      return link + 32'(off);
    end
    return link;
  endfunction

  // Stimulus helpers (drive only).
  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; commit = 1'b0;
    pc_src = 1'b0; jctrl = 1'b0; jrctrl = 1'b0; jalctrl = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] word);
    imem_ready = 1'b1; imem_rdata = word;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic do_commit(input logic br, input logic j, input logic jr,
                           input logic [31:0] tgt);
    commit = 1'b1; pc_src = br; jctrl = j; jalctrl = j; jrctrl = jr; jr_target = tgt;
    step();
    commit = 1'b0; pc_src = 1'b0; jctrl = 1'b0; jalctrl = 1'b0; jrctrl = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    deliver(32'h0000_0000);
    do_commit(1'b0, 1'b0, 1'b1, addr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0 ||
        fetch_err !== 1'b0 || inst !== 32'd0) begin
      errors++;
      $display("FAIL reset: req=%b addr=%h valid=%b err=%b inst=%h expected 1/0/0/0/0",
               imem_req, imem_addr, inst_valid, fetch_err, inst);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    do_reset();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL zw_req: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    deliver(32'h2008_0005);
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h2008_0005 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL zw_inst: valid=%b inst=%h req=%b expected 1/20080005/0",
               inst_valid, inst, imem_req);
    end
    do_commit(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'd4 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL zw_next: addr=%h req=%b valid=%b expected 00000004/1/0",
               imem_addr, imem_req, inst_valid);
    end
    $display("test_zero_wait done");
  endtask

  task automatic test_branch();
    do_reset();
    goto_pc(32'h10);
    deliver(32'h1000_FFFE);
    do_commit(1'b1, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0C) begin
      errors++;
      $display("FAIL beq_taken: addr=%h expected 0000000c", imem_addr);
    end
    goto_pc(32'h10);
    deliver(32'h1000_FFFE);
    do_commit(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL beq_not_taken: addr=%h expected 00000014", imem_addr);
    end
    $display("test_branch done");
  endtask

  task automatic test_jump();
    do_reset();
    goto_pc(32'h4000_0000);
    deliver(32'h0C00_0010);
    checks++;
    if (pc_plus4 !== 32'h4000_0004 || pc !== 32'h4000_0000) begin
      errors++;
      $display("FAIL jal_link: pc=%h pc_plus4=%h expected 40000000/40000004", pc, pc_plus4);
    end
    do_commit(1'b0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h4000_0040) begin
      errors++;
      $display("FAIL jal_target: addr=%h expected 40000040", imem_addr);
    end
    $display("test_jump done");
  endtask

  task automatic test_jr_priority();
    do_reset();
    deliver(32'h0800_0100);
    do_commit(1'b1, 1'b1, 1'b1, 32'h0000_0123);
    checks++;
    if (imem_addr !== 32'h0000_0120) begin
      errors++;
      $display("FAIL jr_priority: addr=%h expected 00000120", imem_addr);
    end
    $display("test_jr_priority done");
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold: cyc=%0d req=%b addr=%h valid=%b expected 1/0/0",
                 i, imem_req, imem_addr, inst_valid);
      end
    end
    deliver(32'hDEAD_BEE0);
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEE0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL wait_done: valid=%b inst=%h err=%b expected 1/deadbee0/0",
               inst_valid, inst, fetch_err);
    end
    $display("test_wait_states done");
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 15; i++) step();
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b req=%b after 15 cycles expected 0/1", fetch_err, imem_req);
    end
    step();
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: err=%b req=%b valid=%b expected 1/0/0",
               fetch_err, imem_req, inst_valid);
    end
    imem_ready = 1'b1; commit = 1'b1;
    step(); step(); step();
    imem_ready = 1'b0; commit = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'd0) begin
      errors++;
      $display("FAIL err_sticky: err=%b req=%b valid=%b pc=%h expected 1/0/0/0",
               fetch_err, imem_req, inst_valid, pc);
    end
    do_reset();
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: err=%b req=%b expected 0/1", fetch_err, imem_req);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_priority();
    do_reset();
    goto_pc(32'h80);
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    rst = 1'b0; imem_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || pc !== 32'd0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_vs_ready: valid=%b pc=%h req=%b expected 0/0/1", inst_valid, pc, imem_req);
    end
    goto_pc(32'h80);
    deliver(32'h0000_0000);
    rst = 1'b1; commit = 1'b1;
    step();
    rst = 1'b0; commit = 1'b0;
    checks++;
    if (pc !== 32'd0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_vs_commit: pc=%h valid=%b expected 0/0", pc, inst_valid);
    end
    // commit asserted while still requesting must not move the PC
    goto_pc(32'h200);
    commit = 1'b1; jrctrl = 1'b1; jr_target = 32'h0000_0F00;
    step(); step();
    checks++;
    if (pc !== 32'h200 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL commit_in_req: pc=%h req=%b expected 00000200/1", pc, imem_req);
    end
    commit = 1'b0; jrctrl = 1'b0;
    $display("test_reset_priority done");
  endtask

  task automatic test_wrap();
    do_reset();
    goto_pc(32'hFFFF_FFFC);
    deliver(32'h0000_0000);
    checks++;
    if (pc_plus4 !== 32'd0) begin
      errors++;
      $display("FAIL wrap_link: pc_plus4=%h expected 00000000", pc_plus4);
    end
    do_commit(1'b0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL wrap_seq: addr=%h expected 00000000", imem_addr);
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] word, tgt;
    logic        br, j, jr;
    int          waits, idles;
    do_reset();
    exp_pc = 32'd0;
    for (int n = 0; n < 60; n++) begin
      waits = $urandom_range(0, 3);
      for (int w = 0; w < waits; w++) step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_req: n=%0d req=%b addr=%h valid=%b expected 1/%h/0",
                 n, imem_req, imem_addr, inst_valid, exp_pc);
      end
      word = $urandom();
      deliver(word);
      idles = $urandom_range(0, 2);
      for (int k = 0; k < idles; k++) begin
        pc_src = 1'($urandom()); jctrl = 1'($urandom()); jrctrl = 1'($urandom());
        jr_target = $urandom();
        step();
      end
      checks++;
      if (inst_valid !== 1'b1 || inst !== word || pc !== exp_pc ||
          pc_plus4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL rnd_hold: n=%0d valid=%b inst=%h pc=%h p4=%h expected 1/%h/%h/%h",
                 n, inst_valid, inst, pc, pc_plus4, word, exp_pc, exp_pc + 32'd4);
      end
      br  = 1'($urandom());
      j   = ($urandom_range(0, 3) == 0);
      jr  = ($urandom_range(0, 3) == 0);
      tgt = $urandom();
      do_commit(br, j, jr, tgt);
      exp_pc = ref_next_pc(exp_pc, word, br, j, jr, tgt);
      $display("rnd n=%0d inst=%h br=%b j=%b jr=%b next=%h got=%h",
               n, word, br, j, jr, exp_pc, imem_addr);
    end
    checks++;
    if (imem_addr !== exp_pc || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL rnd_final: addr=%h err=%b expected %h/0", imem_addr, fetch_err, exp_pc);
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_branch();
    test_jump();
    test_jr_priority();
    test_wait_states();
    test_timeout();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
